// File: rtl/hazard_pkg.sv
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared types and constants for the pipeline hazard controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Forwarding-mux selects, shared with the forwarding unit.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
    logic memwb_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE = 7'b000_0000;
  localparam hz_ctrl_t CTRL_LU   = 7'b110_0100;
  localparam hz_ctrl_t CTRL_BR   = 7'b001_0100;
  localparam hz_ctrl_t CTRL_MW   = 7'b110_1011;

endpackage

`default_nettype wire

// File: rtl/hazard_control_unit_if.sv
// ============================================================================
// Module  : hazard_control_unit_if
// Brief   : Pipeline-side signal bundle of the hazard controller.
//           HAZARD_PERF_CNT_EN adds the performance-counter outputs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface hazard_control_unit_if;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;

  logic       pc_stall;
  logic       ifid_stall;
  logic       ifid_flush;
  logic       idex_stall;
  logic       idex_flush;
  logic       exmem_stall;
  logic       memwb_flush;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;
  logic [31:0] perf_mem_wait_cycles;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, memwb_flush,
           perf_stall_cycles, perf_flushes, perf_mem_wait_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, memwb_flush,
           perf_stall_cycles, perf_flushes, perf_mem_wait_cycles
  );
`else
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, memwb_flush
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, memwb_flush
  );
`endif

endinterface

`default_nettype wire

// File: rtl/hazard_perf_counters.sv
// ============================================================================
// Module  : hazard_perf_counters
// Brief   : Free-running 32-bit event counters for stall/flush/mem-wait cycles.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_ev_i,
  input  logic        flush_ev_i,
  input  logic        mem_ev_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] mem_cnt_o
);

  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] mem_cnt_q;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_cnt_q   <= '0;
    end else begin
      if (stall_ev_i) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_ev_i) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (mem_ev_i)   mem_cnt_q   <= mem_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign mem_cnt_o   = mem_cnt_q;

endmodule

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// ============================================================================
// Module  : hazard_control_unit
// Brief   : Stall/flush/bubble sequencer for the 5-stage pipeline (load-use,
//           taken branch, data-memory wait). HAZARD_PERF_CNT_EN adds counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_control_unit_if.slave  hz
);

  if (LOAD_LATENCY < 1 || LOAD_LATENCY > 7 || LOAD_LATENCY >= (1 << CNT_W)) begin : g_param_chk
    $error("hazard_control_unit: LOAD_LATENCY out of range for CNT_W");
  end

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hz_ctrl_t         ctrl;
  logic             lu;
  logic             mw;
  logic             rs1_hit;
  logic             rs2_hit;

  assign rs1_hit = (hz.ex_rd == hz.id_rs1) && hz.id_uses_rs1;
  assign rs2_hit = (hz.ex_rd == hz.id_rs2) && hz.id_uses_rs2;
  assign lu      = hz.ex_mem_read && (hz.ex_rd != REG_X0) && (rs1_hit || rs2_hit);
  assign mw      = hz.mem_req && !hz.mem_ready;

  always_comb begin
    ctrl    = CTRL_NONE;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (mw) begin
          ctrl    = CTRL_MW;
          state_d = MEM_WAIT;
        end else if (hz.ex_branch_taken) begin
          ctrl = CTRL_BR;
        end else if (lu) begin
          ctrl = CTRL_LU;
          if (LOAD_LATENCY > 1) begin
            state_d = LU_STALL;
            cnt_d   = CNT_W'(LOAD_LATENCY - 1);
          end
        end
      end
      LU_STALL: begin
        // A memory wait freezes the remaining bubble count until release.
        if (mw) begin
          ctrl    = CTRL_MW;
          state_d = MEM_WAIT;
        end else begin
          ctrl  = CTRL_LU;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (!hz.mem_ready) begin
          ctrl = CTRL_MW;
        end else begin
          state_d = (cnt_q != '0) ? LU_STALL : RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    if (!rst_n) ctrl = CTRL_NONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.pc_stall    = ctrl.pc_stall;
  assign hz.ifid_stall  = ctrl.ifid_stall;
  assign hz.ifid_flush  = ctrl.ifid_flush;
  assign hz.idex_stall  = ctrl.idex_stall;
  assign hz.idex_flush  = ctrl.idex_flush;
  assign hz.exmem_stall = ctrl.exmem_stall;
  assign hz.memwb_flush = ctrl.memwb_flush;

`ifdef HAZARD_PERF_CNT_EN
  // Only load-use stalls hold PC without freezing EX/MEM.
  logic stall_ev;
  logic flush_ev;
  logic mem_ev;

  assign stall_ev = ctrl.pc_stall && !ctrl.exmem_stall;
  assign flush_ev = ctrl.ifid_flush;
  assign mem_ev   = ctrl.exmem_stall;

  hazard_perf_counters u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_ev_i  (stall_ev),
    .flush_ev_i  (flush_ev),
    .mem_ev_i    (mem_ev),
    .stall_cnt_o (hz.perf_stall_cycles),
    .flush_cnt_o (hz.perf_flushes),
    .mem_cnt_o   (hz.perf_mem_wait_cycles)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// ============================================================================
// Module  : tb_hazard_control_unit
// Brief   : Self-checking bench; drives LOAD_LATENCY=1 and =3 instances in
//           lockstep. HAZARD_PERF_CNT_EN enables the counter scenario.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_control_unit;

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush}
  localparam logic [6:0] NONE = 7'b000_0000;
  localparam logic [6:0] LU   = 7'b110_0100;
  localparam logic [6:0] BR   = 7'b001_0100;
  localparam logic [6:0] MW   = 7'b110_1011;

  typedef struct {
    logic [6:0] e1;
    logic [6:0] e3;
    string      name;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  sb_t  sb_q[$];

  always #5 clk = ~clk;

  hazard_control_unit_if if_l1 ();
  hazard_control_unit_if if_l3 ();

  hazard_control_unit #(.LOAD_LATENCY(1), .CNT_W(3)) u_l1 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if_l1)
  );

  hazard_control_unit #(.LOAD_LATENCY(3), .CNT_W(3)) u_l3 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if_l3)
  );

  wire [6:0] obs1 = {if_l1.pc_stall, if_l1.ifid_stall, if_l1.ifid_flush, if_l1.idex_stall,
                     if_l1.idex_flush, if_l1.exmem_stall, if_l1.memwb_flush};
  wire [6:0] obs3 = {if_l3.pc_stall, if_l3.ifid_stall, if_l3.ifid_flush, if_l3.idex_stall,
                     if_l3.idex_flush, if_l3.exmem_stall, if_l3.memwb_flush};

  // One cycle: drive at negedge, push expectation, sample mid-low-phase.
  task automatic step(input string name, input logic r,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic br, input logic req, input logic rdy,
                      input logic [6:0] e1, input logic [6:0] e3);
    sb_t ent;
    rst_n = r;
    if_l1.id_rs1 = rs1;  if_l3.id_rs1 = rs1;
    if_l1.id_rs2 = rs2;  if_l3.id_rs2 = rs2;
    if_l1.id_uses_rs1 = u1;  if_l3.id_uses_rs1 = u1;
    if_l1.id_uses_rs2 = u2;  if_l3.id_uses_rs2 = u2;
    if_l1.ex_rd = rd;  if_l3.ex_rd = rd;
    if_l1.ex_mem_read = mr;  if_l3.ex_mem_read = mr;
    if_l1.ex_branch_taken = br;  if_l3.ex_branch_taken = br;
    if_l1.mem_req = req;  if_l3.mem_req = req;
    if_l1.mem_ready = rdy;  if_l3.mem_ready = rdy;
    sb_q.push_back('{e1, e3, name});
    #2;
    ent = sb_q.pop_front();
    n_cmp++;
    if (obs1 !== ent.e1) begin
      n_bad++;
      $display("FAIL %s [LL1]: got %b, expected %b", ent.name, obs1, ent.e1);
    end
    n_cmp++;
    if (obs3 !== ent.e3) begin
      n_bad++;
      $display("FAIL %s [LL3]: got %b, expected %b", ent.name, obs3, ent.e3);
    end
    @(negedge clk);
  endtask

  task automatic idle(input string name, input logic [6:0] e1, input logic [6:0] e3);
    step(name, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e1, e3);
  endtask

  task automatic load_use(input string name, input logic br, input logic [6:0] e1,
                          input logic [6:0] e3);
    step(name, 1'b1, 5'd5, 5'd9, 1'b1, 1'b0, 5'd5, 1'b1, br, 1'b0, 1'b0, e1, e3);
  endtask

  task automatic test_reset();
    step("reset_lu_mw", 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, NONE, NONE);
    idle("reset_release", NONE, NONE);
  endtask

  task automatic test_load_use();
    load_use("lu_c0", 1'b0, LU, LU);
    idle("lu_c1", NONE, LU);
    idle("lu_c2", NONE, LU);
    idle("lu_c3", NONE, NONE);
  endtask

  task automatic test_x0();
    step("x0_rs1", 1'b1, 5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NONE, NONE);
    step("rs1_unused", 1'b1, 5'd4, 5'd3, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, NONE, NONE);
    step("lu_rs2", 1'b1, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU);
    idle("lu_rs2_c1", NONE, LU);
    idle("lu_rs2_c2", NONE, LU);
    idle("lu_rs2_c3", NONE, NONE);
  endtask

  task automatic test_branch_lu();
    load_use("br_over_lu", 1'b1, BR, BR);
    idle("br_after", NONE, NONE);
    step("br_only", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR, BR);
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 4; i++) begin
      step("mw_wait", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, (i == 2), 1'b1, 1'b0, MW, MW);
    end
    step("mw_ready", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, NONE, NONE);
    step("mw_run_br", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR, BR);
    idle("mw_idle", NONE, NONE);
  endtask

  task automatic test_lu_then_mw();
    load_use("lumw_lu", 1'b0, LU, LU);
    step("lumw_wait", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MW, MW);
    step("lumw_ready", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NONE, NONE);
    idle("lumw_resume1", NONE, LU);
    idle("lumw_resume2", NONE, LU);
    idle("lumw_done", NONE, NONE);
  endtask

  task automatic test_reset_mid();
    load_use("rmid_lu", 1'b0, LU, LU);
    step("rmid_assert", 1'b0, 5'd5, 5'd9, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, NONE, NONE);
    idle("rmid_release", NONE, NONE);
    idle("rmid_after", NONE, NONE);
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    step("perf_reset", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE, NONE);
    for (int i = 0; i < 2; i++) begin
      step("perf_br", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR, BR);
    end
    for (int i = 0; i < 3; i++) begin
      step("perf_mw", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MW, MW);
    end
    step("perf_ready", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NONE, NONE);
    idle("perf_idle", NONE, NONE);
    n_cmp++;
    if (if_l1.perf_flushes !== 32'd2) begin
      n_bad++;
      $display("FAIL perf_flushes: got %0d, expected 2", if_l1.perf_flushes);
    end
    n_cmp++;
    if (if_l1.perf_mem_wait_cycles !== 32'd3) begin
      n_bad++;
      $display("FAIL perf_mem_wait_cycles: got %0d, expected 3", if_l1.perf_mem_wait_cycles);
    end
    n_cmp++;
    if (if_l3.perf_stall_cycles !== 32'd0) begin
      n_bad++;
      $display("FAIL perf_stall_cycles: got %0d, expected 0", if_l3.perf_stall_cycles);
    end
    load_use("perf_lu", 1'b0, LU, LU);
    idle("perf_lu_c1", NONE, LU);
    idle("perf_lu_c2", NONE, LU);
    n_cmp++;
    if (if_l3.perf_stall_cycles !== 32'd3) begin
      n_bad++;
      $display("FAIL perf_stall_cycles_lu: got %0d, expected 3", if_l3.perf_stall_cycles);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_load_use();
    test_x0();
    test_branch_lu();
    test_mem_wait();
    test_lu_then_mw();
    test_reset_mid();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core; sits beside the forwarding logic and owns every stall, flush and bubble control.
- Covers three cases:
  - Load-use hazards: the forwarding unit cannot resolve these.
  - Taken-branch flushes: resolved in EX.
  - Multi-cycle data-memory waits: a req/ready handshake.
- A small FSM plus a stall counter sequences multi-cycle stalls so the pipeline registers only see simple hold/bubble strobes.

Parameters:
- LOAD_LATENCY, 1, number of bubble cycles inserted per load-use hazard (1..7).
- CNT_W, 3, width of the load-use stall counter; must hold LOAD_LATENCY.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  5  IF/ID source register 1.
- id_rs2  in  5  IF/ID source register 2.
- id_uses_rs1  in  1  instruction in ID reads rs1.
- id_uses_rs2  in  1  instruction in ID reads rs2.
- ex_rd  in  5  ID/EX destination register.
- ex_mem_read  in  1  ID/EX.MemRead.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  EX/MEM stage performing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  zero IF/ID (NOP).
- idex_stall  out  1  hold ID/EX.
- idex_flush  out  1  load bubble into ID/EX.
- exmem_stall  out  1  hold EX/MEM.
- memwb_flush  out  1  load bubble into MEM/WB.

Behaviour:
- One clock (clk); reset rst_n is asynchronous, active-low.
- rst_n low: state=RUN, counter=0, all outputs 0 regardless of inputs.
- Outputs are combinational from the current state and inputs (zero-latency); state/counter are registered on the clk rising edge.
- Load-use detect (lu): ex_mem_read & ex_rd!=0 & ((ex_rd==id_rs1 & id_uses_rs1) | (ex_rd==id_rs2 & id_uses_rs2)).
- Memory wait (mw): mem_req & ~mem_ready.
- States: RUN, LU_STALL, MEM_WAIT.
- RUN, priority mw > ex_branch_taken > lu:
  - mw: pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush = 1. Next state MEM_WAIT.
  - ex_branch_taken: ifid_flush=1, idex_flush=1, pc_stall=0 (PC takes target). Stay in RUN.
  - lu: pc_stall, ifid_stall, idex_flush = 1. If LOAD_LATENCY>1, go to LU_STALL with counter=LOAD_LATENCY-1; else stay in RUN.
  - none: all outputs 0.
- LU_STALL:
  - Assert pc_stall, ifid_stall, idex_flush; decrement counter.
  - counter==1 this cycle: return to RUN.
  - mw in this state takes priority: MEM_WAIT outputs apply, counter frozen, and LU_STALL resumes after the wait.
- MEM_WAIT:
  - While mem_ready=0: assert the MEM_WAIT output set; ignore branch and lu (EX is frozen, so they re-present after release).
  - mem_ready=1: outputs 0 that cycle (release), then return to RUN, or to LU_STALL if the counter is nonzero.
- Simultaneous ex_branch_taken & lu: branch wins; lu is discarded because the ID instruction is flushed.
- ex_rd==0 never stalls.
- rst_n assertion mid-stall aborts immediately to RUN; no state survives.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cycles[31:0], perf_flushes[31:0], perf_mem_wait_cycles[31:0]:
  - perf_stall_cycles increments every cycle pc_stall=1 due to lu/LU_STALL.
  - perf_flushes increments per taken-branch flush.
  - perf_mem_wait_cycles increments per MEM_WAIT stall cycle.
  - All counters wrap at 2^32 and reset to 0 on rst_n.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- hazard_pkg holds:
  - hz_state_t enum: RUN, LU_STALL, MEM_WAIT.
  - REG_X0 constant (5'd0).
  - Forwarding-select constants FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, shared with the forwarding logic.
- One sub-module, hazard_perf_counters, instantiated only under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use, LOAD_LATENCY=1: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> pc_stall/ifid_stall/idex_flush=1 for exactly 1 cycle; next cycle (bubble in EX) all 0.
- LOAD_LATENCY=3 load-use -> stall/flush asserted 3 consecutive cycles, then RUN; ex_rd=0 with a matching rs gives no stall.
- ex_branch_taken=1 together with lu -> ifid_flush=idex_flush=1, pc_stall=0, no LU_STALL entry.
- mem_req=1, mem_ready=0 for 4 cycles then 1 -> full freeze plus memwb_flush for 4 cycles, all 0 on the ready cycle, state RUN; branch_taken during the wait is ignored.
- rst_n dropped mid-LU_STALL (LOAD_LATENCY=3, cycle 2) -> outputs 0 immediately; after release there is no residual stall.
- With HAZARD_PERF_CNT_EN: 2 branch flushes + 3 mem-wait cycles -> perf_flushes=2, perf_mem_wait_cycles=3, perf_stall_cycles=0.
